score_keeper: RTL and testbench
===============================

// Module: score_keeper
// PURPOSE
//   Game-rule scoring engine for the jump game; direct upstream feeder of display_score.
//   Turns single-cycle landing/fall events from the game FSM into a saturating 10-bit score,
//   a center-landing combo count and a session high score. o_score drives display_score.i_score.
// PARAMETERS
//   SCORE_W    10    width of score/high-score registers (matches display_score.i_score)
//   SCORE_MAX  1023  saturation ceiling for o_score (must be <= 2**SCORE_W-1)
//   COMBO_W    4     width of combo counter
//   COMBO_MAX  15    combo saturation ceiling
// PORTS
//   clk           in   1        system clock; all state on rising edge
//   rst           in   1        asynchronous, active-low reset (0 = reset)
//   i_start       in   1        1-cycle pulse: begin new game
//   i_land        in   1        1-cycle pulse: player landed on next platform
//   i_center      in   1        qualifier for i_land: landing hit platform center
//   i_fall        in   1        1-cycle pulse: player missed, game over
//   o_score       out  SCORE_W  current score, to display_score
//   o_combo       out  COMBO_W  consecutive center landings
//   o_high_score  out  SCORE_W  best score since reset
//   o_state       out  2        FSM state (IDLE=0, PLAY=1, OVER=2)
//   o_score_upd   out  1        1-cycle pulse when o_score changes
//   o_new_record  out  1        level; high in OVER if finished game set a new high score
// BEHAVIOUR
//   Reset (rst=0, async): state IDLE; o_score, o_combo, o_high_score = 0; o_score_upd,
//     o_new_record = 0. Outputs are registered; reset released synchronously to clk.
//   FSM: IDLE --i_start--> PLAY; PLAY --i_fall--> OVER; PLAY --i_start--> PLAY (restart);
//     OVER --i_start--> PLAY. Other inputs ignored outside PLAY.
//   Entering PLAY (any path): o_score=0, o_combo=0, o_new_record=0, same edge.
//   Scoring in PLAY on i_land (latency 1 clk: o_score valid the edge after i_land sampled):
//     i_center=0: add 1; o_combo <= 0.
//     i_center=1: c = min(o_combo+1, COMBO_MAX); o_combo <= c; add 2*c.
//     Sum computed at SCORE_W+COMBO_W+1 bits, clamped to SCORE_MAX; no wrap-around.
//     o_score_upd pulses 1 cycle with the update only if value actually changed
//     (at SCORE_MAX further landings: combo still updates, no pulse).
//   Game over: on i_fall in PLAY -> OVER; if o_score > o_high_score then o_high_score <= o_score
//     and o_new_record <= 1 on the same edge; equal score is not a record. o_score held in OVER.
//   Simultaneous events, priority i_start > i_fall > i_land:
//     i_fall+i_land in PLAY: landing discarded, final score = pre-landing score.
//     i_start with anything: restart; high score NOT updated by the abandoned game.
//   i_center without i_land: ignored. Back-to-back i_land every cycle: each scored.
//   Reset mid-game: all state, including o_high_score, cleared immediately.
// STRUCTURE
//   Shared include jump_game_defs.vh: state encodings ST_IDLE/ST_PLAY/ST_OVER, SCORE_W
//     default, SCORE_MAX default — also used by game FSM and display_score.
//   One sub-module: score_sat_add (combinational: score + increment, clamp to SCORE_MAX).
//   Top: 3-state FSM, combo counter, score reg, high-score reg, upd/record flags.
// TESTING
//   T1 reset: rst=0 mid-PLAY with score 37 -> all outputs 0, state IDLE, no clk needed.
//   T2 start, 3x i_land(center=0) -> o_score 1,2,3, combo 0, three o_score_upd pulses.
//   T3 start, i_land center=1 x4 -> combo 1..4, o_score 2,6,12,20; then center=0 -> 21, combo 0.
//   T4 score 1020, center landing with combo 5 (+12) -> o_score 1023; next land -> 1023, no upd.
//   T5 score 20, i_fall+i_land same cycle -> OVER, score 20, high 20, o_new_record=1;
//     i_start, play to 20, i_fall -> high 20, o_new_record=0.
//   T6 i_start during PLAY at score 15 (high 10) -> score 0, combo 0, high stays 10.

Source files
------------

// File: rtl/score_keeper_pkg.sv
// rtl/score_keeper_pkg.sv - shared state encodings and default widths for the jump game scorer
package score_keeper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_e;

  localparam int SCORE_W_DEF   = 10;
  localparam int SCORE_MAX_DEF = 1023;
  localparam int COMBO_W_DEF   = 4;
  localparam int COMBO_MAX_DEF = 15;

endpackage

// File: rtl/score_sat_add.sv
// rtl/score_sat_add.sv - combinational score + increment, clamped to SCORE_MAX
module score_sat_add #(
  parameter int SCORE_W   = 10,
  parameter int INC_W     = 5,
  parameter int SCORE_MAX = 1023
) (
  input  logic [SCORE_W-1:0] score,
  input  logic [INC_W-1:0]   inc,
  output logic [SCORE_W-1:0] sum
);

  localparam int SUM_W = SCORE_W + INC_W;

  logic [SUM_W-1:0] wide;

  // Widened so the carry out of the score never wraps before the clamp.
  always_comb begin
    wide = {{INC_W{1'b0}}, score} + {{SCORE_W{1'b0}}, inc};
    if (wide > SUM_W'(SCORE_MAX)) begin
      sum = SCORE_W'(SCORE_MAX);
    end else begin
      sum = wide[SCORE_W-1:0];
    end
  end

endmodule

// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - jump game scoring engine: FSM, combo, saturating score, high score
module score_keeper
  import score_keeper_pkg::*;
#(
  parameter int SCORE_W   = SCORE_W_DEF,
  parameter int SCORE_MAX = SCORE_MAX_DEF,
  parameter int COMBO_W   = COMBO_W_DEF,
  parameter int COMBO_MAX = COMBO_MAX_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_land,
  input  logic               i_center,
  input  logic               i_fall,
  output logic [SCORE_W-1:0] o_score,
  output logic [COMBO_W-1:0] o_combo,
  output logic [SCORE_W-1:0] o_high_score,
  output logic [1:0]         o_state,
  output logic               o_score_upd,
  output logic               o_new_record
);

  localparam int INC_W = COMBO_W + 1;

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [COMBO_W-1:0] combo_q, combo_d;
  logic [SCORE_W-1:0] high_q, high_d;
  logic               upd_q, upd_d;
  logic               rec_q, rec_d;

  logic [COMBO_W-1:0] combo_next;
  logic [INC_W-1:0]   inc;
  logic [SCORE_W-1:0] score_sum;

  always_comb begin
    if (combo_q >= COMBO_W'(COMBO_MAX)) begin
      combo_next = COMBO_W'(COMBO_MAX);
    end else begin
      combo_next = combo_q + COMBO_W'(1);
    end
    inc = i_center ? {combo_next, 1'b0} : INC_W'(1);
  end

  score_sat_add #(
    .SCORE_W  (SCORE_W),
    .INC_W    (INC_W),
    .SCORE_MAX(SCORE_MAX)
  ) u_sat_add (
    .score(score_q),
    .inc  (inc),
    .sum  (score_sum)
  );

  // Priority start > fall > land; a restart never credits the abandoned game.
  always_comb begin
    state_d = state_q;
    score_d = score_q;
    combo_d = combo_q;
    high_d  = high_q;
    upd_d   = 1'b0;
    rec_d   = rec_q;
    if (i_start) begin
      state_d = ST_PLAY;
      score_d = '0;
      combo_d = '0;
      rec_d   = 1'b0;
      upd_d   = (score_q != '0);
    end else if (state_q == ST_PLAY) begin
      if (i_fall) begin
        state_d = ST_OVER;
        if (score_q > high_q) begin
          high_d = score_q;
          rec_d  = 1'b1;
        end
      end else if (i_land) begin
        score_d = score_sum;
        combo_d = i_center ? combo_next : '0;
        upd_d   = (score_sum != score_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      score_q <= '0;
      combo_q <= '0;
      high_q  <= '0;
      upd_q   <= 1'b0;
      rec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      combo_q <= combo_d;
      high_q  <= high_d;
      upd_q   <= upd_d;
      rec_q   <= rec_d;
    end
  end

  assign o_score      = score_q;
  assign o_combo      = combo_q;
  assign o_high_score = high_q;
  assign o_state      = state_q;
  assign o_score_upd  = upd_q;
  assign o_new_record = rec_q;

endmodule

// File: tb/tb_score_keeper.sv
// tb/tb_score_keeper.sv - self-checking bench for score_keeper
module tb_score_keeper;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       i_start = 1'b0, i_land = 1'b0, i_center = 1'b0, i_fall = 1'b0;
  logic [9:0] o_score, o_high_score;
  logic [3:0] o_combo;
  logic [1:0] o_state;
  logic       o_score_upd, o_new_record;

  int total = 0;
  int bad   = 0;

  // reference model state
  int m_score, m_combo, m_high, m_state, m_upd, m_rec;

  typedef struct {
    int s, l, c, f;
    int score, combo, high, state, upd, rec;
  } vec_t;

  vec_t vecs[15];

  score_keeper dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_land(i_land), .i_center(i_center),
    .i_fall(i_fall), .o_score(o_score), .o_combo(o_combo), .o_high_score(o_high_score),
    .o_state(o_state), .o_score_upd(o_score_upd), .o_new_record(o_new_record)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_step(input int s, input int l, input int c, input int f);
    int ns;
    m_upd = 0;
    if (s != 0) begin
      m_upd   = (m_score != 0);
      m_score = 0;
      m_combo = 0;
      m_rec   = 0;
      m_state = 1;
    end else if (m_state == 1 && f != 0) begin
      m_state = 2;
      if (m_score > m_high) begin
        m_high = m_score;
        m_rec  = 1;
      end
    end else if (m_state == 1 && l != 0) begin
      if (c != 0) begin
        m_combo = min2(m_combo + 1, 15);
        ns = min2(m_score + 2 * m_combo, 1023);
      end else begin
        m_combo = 0;
        ns = min2(m_score + 1, 1023);
      end
      m_upd   = (ns != m_score);
      m_score = ns;
    end
  endtask

  task automatic model_reset();
    m_score = 0; m_combo = 0; m_high = 0; m_state = 0; m_upd = 0; m_rec = 0;
  endtask

  task automatic drive(input int s, input int l, input int c, input int f);
    i_start = s[0]; i_land = l[0]; i_center = c[0]; i_fall = f[0];
    @(posedge clk);
    model_step(s, l, c, f);
    #1;
    i_start = 1'b0; i_land = 1'b0; i_center = 1'b0; i_fall = 1'b0;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".score"}, int'(o_score), m_score);
    check({tag, ".combo"}, int'(o_combo), m_combo);
    check({tag, ".high"}, int'(o_high_score), m_high);
    check({tag, ".state"}, int'(o_state), m_state);
    check({tag, ".upd"}, int'(o_score_upd), m_upd);
    check({tag, ".rec"}, int'(o_new_record), m_rec);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".score"}, int'(o_score), 0);
    check({tag, ".combo"}, int'(o_combo), 0);
    check({tag, ".high"}, int'(o_high_score), 0);
    check({tag, ".state"}, int'(o_state), 0);
    check({tag, ".upd"}, int'(o_score_upd), 0);
    check({tag, ".rec"}, int'(o_new_record), 0);
  endtask

  task automatic async_reset(input string tag);
    #2 rst = 1'b0;
    #1;
    check_all_zero(tag);
    model_reset();
    rst = 1'b1;
  endtask

  initial begin
    //          s l c f  score combo high st upd rec
    vecs[0]  = '{1, 0, 0, 0,  0, 0,  0, 1, 0, 0};
    vecs[1]  = '{0, 1, 0, 0,  1, 0,  0, 1, 1, 0};
    vecs[2]  = '{0, 1, 0, 0,  2, 0,  0, 1, 1, 0};
    vecs[3]  = '{0, 1, 0, 0,  3, 0,  0, 1, 1, 0};
    vecs[4]  = '{1, 0, 0, 0,  0, 0,  0, 1, 1, 0};
    vecs[5]  = '{0, 1, 1, 0,  2, 1,  0, 1, 1, 0};
    vecs[6]  = '{0, 1, 1, 0,  6, 2,  0, 1, 1, 0};
    vecs[7]  = '{0, 1, 1, 0, 12, 3,  0, 1, 1, 0};
    vecs[8]  = '{0, 1, 1, 0, 20, 4,  0, 1, 1, 0};
    vecs[9]  = '{0, 1, 0, 0, 21, 0,  0, 1, 1, 0};
    vecs[10] = '{0, 0, 1, 0, 21, 0,  0, 1, 0, 0};
    vecs[11] = '{0, 1, 0, 1, 21, 0, 21, 2, 0, 1};
    vecs[12] = '{0, 1, 1, 0, 21, 0, 21, 2, 0, 1};
    vecs[13] = '{1, 0, 0, 0,  0, 0, 21, 1, 1, 0};
    vecs[14] = '{0, 0, 0, 1,  0, 0, 21, 2, 0, 0};

    model_reset();
    #1;
    check_all_zero("reset");
    #12 rst = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      drive(vecs[i].s, vecs[i].l, vecs[i].c, vecs[i].f);
      check($sformatf("vec%0d.score", i), int'(o_score), vecs[i].score);
      check($sformatf("vec%0d.combo", i), int'(o_combo), vecs[i].combo);
      check($sformatf("vec%0d.high", i), int'(o_high_score), vecs[i].high);
      check($sformatf("vec%0d.state", i), int'(o_state), vecs[i].state);
      check($sformatf("vec%0d.upd", i), int'(o_score_upd), vecs[i].upd);
      check($sformatf("vec%0d.rec", i), int'(o_new_record), vecs[i].rec);
    end

    // async reset mid-game at score 37, no clock edge
    drive(1, 0, 0, 0);
    for (int i = 0; i < 37; i++) drive(0, 1, 0, 0);
    check("t1.pre_score", int'(o_score), 37);
    async_reset("t1");

    // saturation: 990 plain + 5 center landings -> 1020 with combo 5
    drive(1, 0, 0, 0);
    for (int i = 0; i < 990; i++) drive(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 1, 1, 0);
    check("t4.pre_score", int'(o_score), 1020);
    check("t4.pre_combo", int'(o_combo), 5);
    drive(0, 1, 1, 0);
    check("t4.sat_score", int'(o_score), 1023);
    check("t4.sat_combo", int'(o_combo), 6);
    check("t4.sat_upd", int'(o_score_upd), 1);
    drive(0, 1, 1, 0);
    check("t4.max_score", int'(o_score), 1023);
    check("t4.max_combo", int'(o_combo), 7);
    check("t4.max_upd", int'(o_score_upd), 0);
    drive(0, 1, 0, 0);
    check("t4.plain_upd", int'(o_score_upd), 0);
    check("t4.plain_combo", int'(o_combo), 0);
    async_reset("t4rst");

    // fall+land: landing discarded; equal score is not a record
    drive(1, 0, 0, 0);
    for (int i = 0; i < 20; i++) drive(0, 1, 0, 0);
    drive(0, 1, 1, 1);
    check("t5.score", int'(o_score), 20);
    check("t5.high", int'(o_high_score), 20);
    check("t5.rec", int'(o_new_record), 1);
    check("t5.state", int'(o_state), 2);
    drive(1, 0, 0, 0);
    for (int i = 0; i < 20; i++) drive(0, 1, 0, 0);
    drive(0, 0, 0, 1);
    check("t5b.high", int'(o_high_score), 20);
    check("t5b.rec", int'(o_new_record), 0);
    async_reset("t5rst");

    // restart mid-game does not credit the abandoned score
    drive(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) drive(0, 1, 0, 0);
    drive(0, 0, 0, 1);
    drive(1, 0, 0, 0);
    for (int i = 0; i < 15; i++) drive(0, 1, 0, 0);
    drive(1, 1, 1, 1);
    check("t6.score", int'(o_score), 0);
    check("t6.combo", int'(o_combo), 0);
    check("t6.high", int'(o_high_score), 10);
    check("t6.state", int'(o_state), 1);
    check_model("t6m");

    // randomized run against the model
    for (int n = 0; n < 4000; n++) begin
      int s, l, c, f;
      s = ($urandom_range(0, 199) == 0);
      f = ($urandom_range(0, 99) == 0);
      l = ($urandom_range(0, 1) == 0);
      c = ($urandom_range(0, 3) != 0);
      if (m_state != 1 && $urandom_range(0, 9) == 0) s = 1;
      drive(s, l, c, f);
      check_model("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
